// File: rtl/wshb_arbiter.sv
// -----------------------------------------------------------------------------
// wshb_arbiter
//
// Purpose:
//   This block is a two-master Wishbone arbiter. It shares the single SDRAM
//   Wishbone slave port in the sys_clk domain between two masters:
//     - Master 0 is the video framebuffer reader, which feeds the VGA pixel FIFO.
//     - Master 1 is the pattern/framebuffer writer.
//   The arbiter gives the slave to one master for a whole Wishbone cycle. A
//   rising cyc starts the cycle and a falling cyc ends it. The owner's request
//   signals are forwarded to the slave combinationally. The slave responses are
//   routed back only to the owner. The data path has no register stage.
//
// Arbitration:
//   - Default build: round-robin. When both masters contend, the master that
//     was not granted last wins. After reset, m0 wins the first contention.
//   - Build with WSHB_ARB_FIXED_PRIO_EN defined: fixed priority. m0 wins every
//     contention, and the round-robin history register is not built.
//   - A grant is never revoked while the owner holds cyc.
//
// Ports:
//   sys_clk, sys_rst_n          Clock. Asynchronous active-low reset.
//   m0_* / m1_* (inputs)        Master request: cyc, stb, we, adr, dat_ms,
//                               sel, cti, bte.
//   m0_* / m1_* (outputs)       Master response: ack, err, rty, dat_sm.
//   s_* (outputs)               Request to the SDRAM slave. All zero when idle.
//   s_ack, s_err, s_rty,
//   s_dat_sm (inputs)           Response from the SDRAM slave.
//   grant[1:0]                  Registered one-hot owner. 2'b00 when idle.
// -----------------------------------------------------------------------------
module wshb_arbiter #(
   parameter int ADR_W = 32,
   parameter int DAT_W = 32
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,

   // master 0 (video reader)
   input  logic                 m0_cyc,
   input  logic                 m0_stb,
   input  logic                 m0_we,
   input  logic [ADR_W-1:0]     m0_adr,
   input  logic [DAT_W-1:0]     m0_dat_ms,
   input  logic [DAT_W/8-1:0]   m0_sel,
   input  logic [2:0]           m0_cti,
   input  logic [1:0]           m0_bte,
   output logic                 m0_ack,
   output logic                 m0_err,
   output logic                 m0_rty,
   output logic [DAT_W-1:0]     m0_dat_sm,

   // master 1 (pattern writer)
   input  logic                 m1_cyc,
   input  logic                 m1_stb,
   input  logic                 m1_we,
   input  logic [ADR_W-1:0]     m1_adr,
   input  logic [DAT_W-1:0]     m1_dat_ms,
   input  logic [DAT_W/8-1:0]   m1_sel,
   input  logic [2:0]           m1_cti,
   input  logic [1:0]           m1_bte,
   output logic                 m1_ack,
   output logic                 m1_err,
   output logic                 m1_rty,
   output logic [DAT_W-1:0]     m1_dat_sm,

   // shared SDRAM slave
   output logic                 s_cyc,
   output logic                 s_stb,
   output logic                 s_we,
   output logic [ADR_W-1:0]     s_adr,
   output logic [DAT_W-1:0]     s_dat_ms,
   output logic [DAT_W/8-1:0]   s_sel,
   output logic [2:0]           s_cti,
   output logic [1:0]           s_bte,
   input  logic                 s_ack,
   input  logic                 s_err,
   input  logic                 s_rty,
   input  logic [DAT_W-1:0]     s_dat_sm,

   output logic [1:0]           grant
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t       state_reg;
   state_t       state_next;
   logic [1:0]   grant_reg;
   logic [1:0]   owner;              // one-hot decode of the current state
   logic         m0_wins;            // contention winner when both request in IDLE

   // -------------------------------------------------------------------------
   // Contention policy
   // -------------------------------------------------------------------------
`ifdef WSHB_ARB_FIXED_PRIO_EN
   // The video reader always wins. This bounds its refill latency.
   assign m0_wins = 1'b1;
`else
   logic last_reg;                   // master granted most recently (0 = m0, 1 = m1)
   logic last_next;

   // The history is updated when the owner releases. It starts at 1 so that
   // m0 wins the first contention after reset.
   always_comb begin
      last_next = last_reg;
      if (state_reg == GNT0 && !m0_cyc) begin
         last_next = 1'b0;
      end else if (state_reg == GNT1 && !m1_cyc) begin
         last_next = 1'b1;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         last_reg <= 1'b1;
      end else begin
         last_reg <= last_next;
      end
   end

   assign m0_wins = last_reg;
`endif

   // -------------------------------------------------------------------------
   // Grant FSM
   // -------------------------------------------------------------------------
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_reg <= IDLE;
         grant_reg <= 2'b00;
      end else begin
         state_reg <= state_next;
         // grant_reg is loaded from the next state, so it always matches
         // state_reg while still coming straight from a flop.
         grant_reg <= {state_next == GNT1, state_next == GNT0};
      end
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE: begin
            if (m0_cyc && m1_cyc) begin
               state_next = m0_wins ? GNT0 : GNT1;
            end else if (m0_cyc) begin
               state_next = GNT0;
            end else if (m1_cyc) begin
               state_next = GNT1;
            end
         end
         // When the owner releases, a waiting master takes over directly.
         // The releasing master's cyc is low in this cycle, so the waiting
         // master wins even if the releasing master requests again right away.
         GNT0: begin
            if (!m0_cyc) begin
               state_next = m1_cyc ? GNT1 : IDLE;
            end
         end
         GNT1: begin
            if (!m1_cyc) begin
               state_next = m0_cyc ? GNT0 : IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Ownership decode. Each master gets one bit.
   // -------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_owner
         localparam state_t OWN_STATE = (gi == 0) ? GNT0 : GNT1;
         assign owner[gi] = (state_reg == OWN_STATE);
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Request path: the owner's signals go straight to the slave.
   // s_cyc and s_stb are gated by the owner's cyc, so the slave sees the
   // release in the same cycle the owner drops cyc.
   // -------------------------------------------------------------------------
   always_comb begin
      s_cyc    = 1'b0;
      s_stb    = 1'b0;
      s_we     = 1'b0;
      s_adr    = '0;
      s_dat_ms = '0;
      s_sel    = '0;
      s_cti    = 3'b000;
      s_bte    = 2'b00;
      if (owner[0]) begin
         s_cyc    = m0_cyc;
         s_stb    = m0_stb & m0_cyc;
         s_we     = m0_we;
         s_adr    = m0_adr;
         s_dat_ms = m0_dat_ms;
         s_sel    = m0_sel;
         s_cti    = m0_cti;
         s_bte    = m0_bte;
      end else if (owner[1]) begin
         s_cyc    = m1_cyc;
         s_stb    = m1_stb & m1_cyc;
         s_we     = m1_we;
         s_adr    = m1_adr;
         s_dat_ms = m1_dat_ms;
         s_sel    = m1_sel;
         s_cti    = m1_cti;
         s_bte    = m1_bte;
      end
   end

   // -------------------------------------------------------------------------
   // Response path: the handshake signals are qualified by ownership.
   // Read data is broadcast to both masters; only the owner's ack marks it valid.
   // -------------------------------------------------------------------------
   assign m0_ack    = s_ack & owner[0];
   assign m0_err    = s_err & owner[0];
   assign m0_rty    = s_rty & owner[0];
   assign m0_dat_sm = s_dat_sm;

   assign m1_ack    = s_ack & owner[1];
   assign m1_err    = s_err & owner[1];
   assign m1_rty    = s_rty & owner[1];
   assign m1_dat_sm = s_dat_sm;

   assign grant = grant_reg;

endmodule

// File: tb/tb_wshb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wshb_arbiter
//
// Purpose:
//   Directed, self-checking bench for wshb_arbiter.
//   - Two master models issue single transfers and bursts. Both are driven
//     from the main initial block.
//   - A combinational slave model answers requests. Wait states and error
//     injection are programmable.
//   - Each expected beat is pushed onto a scoreboard queue, in the order the
//     arbiter should serve it. The entry is popped when a response appears at
//     a master port.
//   - The grant sequence of each scenario is logged, then compared against the
//     expected owner order.
// -----------------------------------------------------------------------------
module tb_wshb_arbiter;

   localparam int ADR_W = 32;
   localparam int DAT_W = 32;

   logic              sys_clk = 1'b0;
   logic              sys_rst_n = 1'b0;

   logic              m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
   logic [ADR_W-1:0]  m0_adr, m1_adr;
   logic [DAT_W-1:0]  m0_dat_ms, m1_dat_ms;
   logic [3:0]        m0_sel, m1_sel;
   logic [2:0]        m0_cti, m1_cti;
   logic [1:0]        m0_bte, m1_bte;
   logic              m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
   logic [DAT_W-1:0]  m0_dat_sm, m1_dat_sm;

   logic              s_cyc, s_stb, s_we, s_ack, s_err, s_rty;
   logic [ADR_W-1:0]  s_adr;
   logic [DAT_W-1:0]  s_dat_ms, s_dat_sm;
   logic [3:0]        s_sel;
   logic [2:0]        s_cti;
   logic [1:0]        s_bte;
   logic [1:0]        grant;

   // slave model controls
   logic              ack_en = 1'b1;
   logic              err_on = 1'b0;
   logic [31:0]       err_adr = 32'h0;
   logic              wait_mode = 1'b0;
   int                cyc_cnt = 0;

   always #5 sys_clk = ~sys_clk;

   wshb_arbiter #(.ADR_W(ADR_W), .DAT_W(DAT_W)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
      .m0_dat_ms(m0_dat_ms), .m0_sel(m0_sel), .m0_cti(m0_cti), .m0_bte(m0_bte),
      .m0_ack(m0_ack), .m0_err(m0_err), .m0_rty(m0_rty), .m0_dat_sm(m0_dat_sm),
      .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
      .m1_dat_ms(m1_dat_ms), .m1_sel(m1_sel), .m1_cti(m1_cti), .m1_bte(m1_bte),
      .m1_ack(m1_ack), .m1_err(m1_err), .m1_rty(m1_rty), .m1_dat_sm(m1_dat_sm),
      .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
      .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
      .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty), .s_dat_sm(s_dat_sm),
      .grant(grant)
   );

   // zero-wait slave; ack_en inserts wait states, err_adr selects an error beat
   wire err_hit = err_on && (s_adr == err_adr);
   assign s_ack    = s_cyc & s_stb & ack_en & ~err_hit;
   assign s_err    = s_cyc & s_stb & ack_en & err_hit;
   assign s_rty    = 1'b0;
   assign s_dat_sm = s_adr ^ 32'hDEAD_0000;

   // ---------------------------------------------------------------- checking
   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   typedef struct packed {
      logic        m;
      logic [31:0] adr;
      logic        we;
      logic [2:0]  cti;
      logic        err;
   } exp_t;

   exp_t        sb[$];
   logic [1:0]  glog[$];
   logic [1:0]  glast;

   function automatic logic [31:0] wdat(input int m, input logic [31:0] a);
      return a ^ ((m == 0) ? 32'h1111_0000 : 32'h2222_0000);
   endfunction

   function automatic logic [3:0] sel_of(input int m);
      return (m == 0) ? 4'hF : 4'h3;
   endfunction

   task automatic push_burst(input int m, input logic [31:0] adr, input int n,
                             input logic we, input int err_idx);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.m   = (m != 0);
         e.adr = adr + 32'(4 * i);
         e.we  = we;
         e.cti = (n == 1) ? 3'b000 : ((i == n - 1) ? 3'b111 : 3'b010);
         e.err = (i == err_idx);
         sb.push_back(e);
      end
   endtask

   // ----------------------------------------------------------- master models
   int          rem[2];
   int          bursts[2];
   int          blen[2];
   logic [31:0] cur_adr[2];
   logic        mwe[2];
   logic        gap[2];

   task automatic start(input int m, input logic [31:0] adr, input int len,
                        input int nb, input logic we);
      rem[m] = 0; bursts[m] = nb; blen[m] = len; cur_adr[m] = adr;
      mwe[m] = we; gap[m] = 1'b0;
   endtask

   function automatic logic [2:0] cti_of(input int m);
      if (blen[m] == 1) return 3'b000;
      return (rem[m] == 1) ? 3'b111 : 3'b010;
   endfunction

   task automatic drive_masters();
      for (int m = 0; m < 2; m++) begin
         if (gap[m]) gap[m] = 1'b0;        // one released cycle after each burst
         else if (rem[m] == 0 && bursts[m] > 0) begin
            rem[m] = blen[m];
            bursts[m]--;
         end
      end
      m0_cyc = (rem[0] > 0); m0_stb = (rem[0] > 0); m0_we = mwe[0];
      m0_adr = cur_adr[0]; m0_dat_ms = wdat(0, cur_adr[0]); m0_sel = sel_of(0);
      m0_cti = cti_of(0); m0_bte = 2'b00;
      m1_cyc = (rem[1] > 0); m1_stb = (rem[1] > 0); m1_we = mwe[1];
      m1_adr = cur_adr[1]; m1_dat_ms = wdat(1, cur_adr[1]); m1_sel = sel_of(1);
      m1_cti = cti_of(1); m1_bte = 2'b00;
      ack_en = wait_mode ? (cyc_cnt % 3 == 2) : 1'b1;
      cyc_cnt++;
   endtask

   // called on the falling edge: score responses and advance the masters
   task automatic sample();
      logic [3:0] resp;
      logic [3:0] exp_resp;
      exp_t       e;
      if (grant !== glast) begin
         glog.push_back(grant);
         glast = grant;
      end
      resp = {m1_err, m1_ack, m0_err, m0_ack};
      if (resp != 4'b0000) begin
         if (sb.size() == 0) begin
            chk("unexpected_resp", 64'(resp), 64'h0);
         end else begin
            e = sb.pop_front();
            exp_resp = e.m ? (e.err ? 4'b1000 : 4'b0100) : (e.err ? 4'b0010 : 4'b0001);
            chk("resp_route", 64'(resp), 64'(exp_resp));
            chk("rty", 64'({m1_rty, m0_rty}), 64'h0);
            chk("grant_owner", 64'(grant), e.m ? 64'h2 : 64'h1);
            chk("s_adr", 64'(s_adr), 64'(e.adr));
            chk("s_we", 64'(s_we), 64'(e.we));
            chk("s_cti", 64'(s_cti), 64'(e.cti));
            chk("s_sel", 64'(s_sel), 64'(sel_of(int'(e.m))));
            if (e.we)
               chk("s_dat_ms", 64'(s_dat_ms), 64'(wdat(int'(e.m), e.adr)));
            else
               chk("dat_sm", e.m ? 64'(m1_dat_sm) : 64'(m0_dat_sm),
                   64'(e.adr ^ 32'hDEAD_0000));
            $display("beat m%0d adr=0x%0h we=%0d cti=%0d resp=%b",
                     e.m, s_adr, s_we, s_cti, resp);
         end
      end
      for (int m = 0; m < 2; m++) begin
         if (((m == 0) ? (m0_ack | m0_err) : (m1_ack | m1_err)) && rem[m] > 0) begin
            rem[m]--;
            cur_adr[m] = cur_adr[m] + 32'd4;
            if (rem[m] == 0) gap[m] = 1'b1;
         end
      end
   endtask

   task automatic cycle();
      @(negedge sys_clk);
      sample();
      @(posedge sys_clk);
      #1;
      drive_masters();
   endtask

   task automatic begin_scenario();
      glog.delete();
      glast = grant;
      cyc_cnt = 0;
   endtask

   task automatic run_until_idle(input string tag, input logic [63:0] exp_seq, input int exp_len);
      int n = 0;
      logic [63:0] pack = 0;
      while ((sb.size() > 0 || rem[0] > 0 || rem[1] > 0 || bursts[0] > 0 || bursts[1] > 0)
             && n < 400) begin
         cycle();
         n++;
      end
      chk({tag, "_timeout"}, 64'(n < 400), 64'h1);
      for (int i = 0; i < 3; i++) cycle();
      chk({tag, "_idle_grant"}, 64'(grant), 64'h0);
      chk({tag, "_idle_scyc"}, 64'({s_cyc, s_stb}), 64'h0);
      foreach (glog[i]) pack = (pack << 2) | 64'(glog[i]);
      chk({tag, "_grant_len"}, 64'(glog.size()), 64'(exp_len));
      chk({tag, "_grant_seq"}, pack, exp_seq);
      $display("scenario %s done in %0d cycles, %0d grant changes", tag, n, glog.size());
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------ stimulus
   initial begin
      for (int m = 0; m < 2; m++) begin
         rem[m] = 0; bursts[m] = 0; blen[m] = 1; cur_adr[m] = 0; mwe[m] = 0; gap[m] = 0;
      end
      drive_masters();
      repeat (2) @(posedge sys_clk);
      @(negedge sys_clk);
      chk("rst_grant", 64'(grant), 64'h0);
      chk("rst_scyc_stb", 64'({s_cyc, s_stb}), 64'h0);
      chk("rst_acks", 64'({m1_ack, m0_ack}), 64'h0);
      chk("rst_sadr", 64'(s_adr), 64'h0);
      sys_rst_n = 1'b1;
      @(posedge sys_clk); #1;

      // 1: m1 alone, four single writes
      begin_scenario();
      start(1, 32'h100, 1, 4, 1'b1);
      for (int i = 0; i < 4; i++) push_burst(1, 32'h100 + 32'(4 * i), 1, 1'b1, -1);
      run_until_idle("single_m1", 64'({2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00}), 8);

      // 2: simultaneous first request, m0 first and then m1 with no idle gap
      begin_scenario();
      start(0, 32'h200, 2, 1, 1'b0);
      start(1, 32'h300, 2, 1, 1'b1);
      push_burst(0, 32'h200, 2, 1'b0, -1);
      push_burst(1, 32'h300, 2, 1'b1, -1);
      run_until_idle("simult", 64'({2'b01, 2'b10, 2'b00}), 3);

      // 3: saturation with repeated 8-beat bursts; grants alternate
      begin_scenario();
      start(0, 32'h1000, 8, 3, 1'b0);
      start(1, 32'h2000, 8, 3, 1'b1);
      for (int b = 0; b < 3; b++) begin
         push_burst(0, 32'h1000 + 32'(32 * b), 8, 1'b0, -1);
         push_burst(1, 32'h2000 + 32'(32 * b), 8, 1'b1, -1);
      end
      run_until_idle("saturate",
         64'({2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00}), 7);

      // 4: slave acks every third cycle during an m0 burst while m1 waits
      begin_scenario();
      wait_mode = 1'b1;
      start(0, 32'h500, 4, 1, 1'b0);
      start(1, 32'h600, 1, 1, 1'b1);
      push_burst(0, 32'h500, 4, 1'b0, -1);
      push_burst(1, 32'h600, 1, 1'b1, -1);
      run_until_idle("waitst", 64'({2'b01, 2'b10, 2'b00}), 3);
      wait_mode = 1'b0;

      // 5: error on m1's second beat is routed only to m1
      begin_scenario();
      err_on = 1'b1; err_adr = 32'h704;
      start(1, 32'h700, 3, 1, 1'b1);
      push_burst(1, 32'h700, 3, 1'b1, 1);
      run_until_idle("err_m1", 64'({2'b10, 2'b00}), 2);
      err_on = 1'b0;

      // 6: m0 single read; this makes m0 the most recent owner
      begin_scenario();
      start(0, 32'h800, 1, 1, 1'b0);
      push_burst(0, 32'h800, 1, 1'b0, -1);
      run_until_idle("read_m0", 64'({2'b01, 2'b00}), 2);

      // 7: asynchronous reset in the middle of an m0 burst
      start(0, 32'h400, 8, 1, 1'b0);
      push_burst(0, 32'h400, 8, 1'b0, -1);
      repeat (4) cycle();
      #2;
      chk("pre_rst_scyc", 64'(s_cyc), 64'h1);
      sys_rst_n = 1'b0;
      #1;
      chk("arst_scyc_stb", 64'({s_cyc, s_stb}), 64'h0);
      chk("arst_m0_ack", 64'(m0_ack), 64'h0);
      chk("arst_grant", 64'(grant), 64'h0);
      $display("async reset asserted mid-burst: s_cyc=%0d grant=%b", s_cyc, grant);
      sb.delete();
      for (int m = 0; m < 2; m++) begin rem[m] = 0; bursts[m] = 0; gap[m] = 0; end
      drive_masters();
      repeat (2) @(posedge sys_clk);
      @(negedge sys_clk);
      chk("rst_hold_grant", 64'(grant), 64'h0);
      sys_rst_n = 1'b1;
      @(posedge sys_clk); #1;

      // 8: the first contention after reset grants m0 again
      begin_scenario();
      start(0, 32'h900, 1, 1, 1'b0);
      start(1, 32'hA00, 1, 1, 1'b1);
      push_burst(0, 32'h900, 1, 1'b0, -1);
      push_burst(1, 32'hA00, 1, 1'b1, -1);
      run_until_idle("post_rst", 64'({2'b01, 2'b10, 2'b00}), 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
